ph_rmw_port: RTL and testbench

PH_RMW_PORT -- requirements
Module: ph_rmw_port

---
 rtl/ph_rmw_port_pkg.sv | 33 +++
 rtl/ph_rmw_port_addr_calc.sv | 62 ++++++
 rtl/ph_rmw_port.sv | 171 +++++++++++++++++
 tb/tb_ph_rmw_port.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ph_rmw_port_pkg.sv
// rtl/ph_rmw_port_pkg.sv - shared ant-colony package: step codes, port states, address-width helper
//
// Purpose : types and helpers shared by the pheromone RMW port and by agents
//           that reuse the target/address calculator.
// Contents: step_e  - move encoding (+x, -x, +y, -y)
//           state_e - RMW port states
//           addr_w  - address width for a square map of side map_len

package ph_rmw_port_pkg;

   typedef enum logic [1:0] {
      STEP_PX = 2'd0,
      STEP_NX = 2'd1,
      STEP_PY = 2'd2,
      STEP_NY = 2'd3
   } step_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_SOLV = 3'd3,
      ST_FIN  = 3'd4
   } state_e;

   // Width needed to address every cell of a map_len x map_len map.
   function automatic int addr_w(input int map_len);
      int cells;
      cells = map_len * map_len;
      return (cells <= 2) ? 1 : $clog2(cells);
   endfunction

endpackage

// File: rtl/ph_rmw_port_addr_calc.sv
// rtl/ph_rmw_port_addr_calc.sv - combinational target cell and linear address from position and step
//
// Purpose : moves {y,x} one cell in the direction given by step, flags the
//           target as off-map when either coordinate leaves [0, MAP_LEN),
//           and forms the row-major address ty*MAP_LEN+tx.
// Ports   : pos  in  2*POS_ADDR  agent position {y,x}
//           step in  2           move code (step_e)
//           addr out AW          target address, zero when off-map
//           oob  out 1           target lies outside the map

module ph_addr_calc
   import ph_rmw_port_pkg::*;
#(
   parameter int POS_ADDR = 4,
   parameter int MAP_LEN  = 10,
   parameter int AW       = addr_w(MAP_LEN)
)
(
   input  logic [2*POS_ADDR-1:0] pos,
   input  logic [1:0]            step,
   output logic [AW-1:0]         addr,
   output logic                  oob
);

   // Two extra bits: one for x+1 overflowing POS_ADDR, one so that 0-1
   // wraps to a huge unsigned value and fails the same bound check.
   localparam int             CW    = POS_ADDR + 2;
   localparam logic [CW-1:0]  LEN_C = CW'(MAP_LEN);

   logic [CW-1:0] x_ext;
   logic [CW-1:0] y_ext;
   logic [CW-1:0] tx;
   logic [CW-1:0] ty;

   always_comb begin
      x_ext = {2'b00, pos[POS_ADDR-1:0]};
      y_ext = {2'b00, pos[2*POS_ADDR-1:POS_ADDR]};
      tx    = x_ext;
      ty    = y_ext;
      case (step_e'(step))
         STEP_PX: tx = x_ext + CW'(1);
         STEP_NX: tx = x_ext - CW'(1);
         STEP_PY: ty = y_ext + CW'(1);
         STEP_NY: ty = y_ext - CW'(1);
         default: begin
            tx = x_ext;
            ty = y_ext;
         end
      endcase

      // Unsigned compare also catches the -1 wrap.
      oob = (tx >= LEN_C) || (ty >= LEN_C);

      // In-map addresses always fit in AW bits, so modulo-2^AW math is exact.
      if (oob) begin
         addr = '0;
      end else begin
         addr = AW'(ty) * AW'(MAP_LEN) + AW'(tx);
      end
   end

endmodule

// File: rtl/ph_rmw_port.sv
// rtl/ph_rmw_port.sv - pheromone read-modify-write port for one granted agent
//
// Purpose : on a start pulse, latches the agent's position, move and solved
//           flag, then either deposits pheromone on the target cell
//           (read, saturating add, write) or, for a solved agent, marks the
//           target cell with PH_MAX. Off-map targets touch no memory.
// Ports   : clk        in   rising-edge clock
//           rst        in   synchronous active-high reset
//           start      in   one-cycle grant pulse, honoured only when idle
//           pos        in   agent position {y,x}
//           step       in   move code (step_e)
//           solved     in   granted agent has reached the goal
//           mem_addr   out  pheromone RAM address
//           mem_re     out  read strobe (data returns the next cycle)
//           mem_we     out  write strobe
//           mem_wdata  out  write data
//           mem_rdata  in   read data, valid one cycle after mem_re
//           busy       out  transaction in progress
//           done       out  one-cycle completion pulse
//           oob        out  target was off-map, valid with done

module ph_rmw_port
   import ph_rmw_port_pkg::*;
#(
   parameter int POS_ADDR = 4,
   parameter int MAP_LEN  = 10,
   parameter int PH_W     = 8,
   parameter int DEPOSIT  = 4,
   parameter int PH_MAX   = 2**PH_W - 1
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [2*POS_ADDR-1:0]        pos,
   input  logic [1:0]                   step,
   input  logic                         solved,
   output logic [addr_w(MAP_LEN)-1:0]   mem_addr,
   output logic                         mem_re,
   output logic                         mem_we,
   output logic [PH_W-1:0]              mem_wdata,
   input  logic [PH_W-1:0]              mem_rdata,
   output logic                         busy,
   output logic                         done,
   output logic                         oob
);

   localparam int              AW       = addr_w(MAP_LEN);
   localparam logic [PH_W-1:0] PH_MAX_C = PH_W'(PH_MAX);

   state_e                state_q;
   logic [2*POS_ADDR-1:0] pos_q;
   logic [1:0]            step_q;
   logic                  solved_q;
   logic [AW-1:0]         mem_addr_q;
   logic                  mem_re_q;
   logic                  mem_we_q;
   logic                  done_q;
   logic                  oob_q;
   logic                  oob_hold_q;

   logic [2*POS_ADDR-1:0] calc_pos_d;
   logic [1:0]            calc_step_d;
   logic [AW-1:0]         calc_addr;
   logic                  calc_oob;
   logic [PH_W:0]         sum_d;

   // While idle the calculator looks at the live inputs so the first strobe
   // can be registered on the start edge; afterwards it sees the latched copy.
   assign calc_pos_d  = (state_q == ST_IDLE) ? pos  : pos_q;
   assign calc_step_d = (state_q == ST_IDLE) ? step : step_q;

   ph_addr_calc #(
      .POS_ADDR (POS_ADDR),
      .MAP_LEN  (MAP_LEN),
      .AW       (AW)
   ) u_addr_calc (
      .pos  (calc_pos_d),
      .step (calc_step_d),
      .addr (calc_addr),
      .oob  (calc_oob)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pos_q      <= '0;
         step_q     <= '0;
         solved_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_re_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         done_q     <= 1'b0;
         oob_q      <= 1'b0;
         oob_hold_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  pos_q      <= pos;
                  step_q     <= step;
                  solved_q   <= solved;
                  oob_hold_q <= calc_oob;
                  mem_addr_q <= calc_addr;
                  if (calc_oob) begin
                     // Off-map: spend the strobe slot with nothing driven so
                     // the done timing matches the solved path.
                     state_q <= ST_SOLV;
                  end else if (solved) begin
                     state_q  <= ST_SOLV;
                     mem_we_q <= 1'b1;
                  end else begin
                     state_q  <= ST_RD;
                     mem_re_q <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               mem_re_q <= 1'b0;
               mem_we_q <= 1'b1;
               state_q  <= ST_WR;
            end
            ST_WR, ST_SOLV: begin
               mem_we_q   <= 1'b0;
               mem_addr_q <= '0;
               done_q     <= 1'b1;
               oob_q      <= oob_hold_q;
               state_q    <= ST_FIN;
            end
            ST_FIN: begin
               done_q  <= 1'b0;
               oob_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               mem_re_q <= 1'b0;
               mem_we_q <= 1'b0;
               done_q   <= 1'b0;
               oob_q    <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   // One extra bit keeps the carry so saturation is detected rather than wrapped.
   assign sum_d = {1'b0, mem_rdata} + (PH_W+1)'(DEPOSIT);

   // Write data depends on read data that only arrives in the WR cycle, so it
   // is formed combinationally and forced to zero whenever no write is driven.
   always_comb begin
      mem_wdata = '0;
      if (mem_we_q) begin
         if (solved_q) begin
            mem_wdata = PH_MAX_C;
         end else if (sum_d > {1'b0, PH_MAX_C}) begin
            mem_wdata = PH_MAX_C;
         end else begin
            mem_wdata = sum_d[PH_W-1:0];
         end
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_re   = mem_re_q;
   assign mem_we   = mem_we_q;
   assign done     = done_q;
   assign oob      = oob_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ph_rmw_port.sv
// tb/tb_ph_rmw_port.sv - scoreboard bench for the pheromone RMW port

module tb_ph_rmw_port;

   localparam int MAP_LEN = 10;
   localparam int PH_W    = 8;
   localparam int DEPOSIT = 4;
   localparam int PH_MAX  = 255;
   localparam int AW      = 7;
   localparam int CELLS   = MAP_LEN * MAP_LEN;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [7:0]      pos = 8'h00;
   logic [1:0]      step = 2'd0;
   logic            solved = 1'b0;
   logic [AW-1:0]   mem_addr;
   logic            mem_re;
   logic            mem_we;
   logic [PH_W-1:0] mem_wdata;
   logic [PH_W-1:0] mem_rdata = '0;
   logic            busy;
   logic            done;
   logic            oob;

   ph_rmw_port #(
      .POS_ADDR (4),
      .MAP_LEN  (MAP_LEN),
      .PH_W     (PH_W),
      .DEPOSIT  (DEPOSIT),
      .PH_MAX   (PH_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pos       (pos),
      .step      (step),
      .solved    (solved),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done),
      .oob       (oob)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM seen by the DUT
   logic [PH_W-1:0] ram [CELLS];
   always @(posedge clk) begin
      if (mem_re && int'(mem_addr) < CELLS) mem_rdata <= ram[mem_addr];
      if (mem_we && int'(mem_addr) < CELLS) ram[mem_addr] <= mem_wdata;
   end

   // Reference model state
   int ref_mem [CELLS];
   typedef struct {
      int cyc;
      int kind;   // 0 read, 1 write, 2 done
      int addr;
      int data;
      int oob;
   } exp_t;
   exp_t expq [$];

   int checks = 0;
   int errors = 0;
   int busy_lo = -1;
   int busy_hi = -2;
   bit mon_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int c, input int k, input int a, input int d, input int o);
      exp_t e;
      e.cyc = c; e.kind = k; e.addr = a; e.data = d; e.oob = o;
      expq.push_back(e);
   endtask

   task automatic observe(input int kind, input int addr, input int data, input int o);
      exp_t e;
      if (expq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_op: got kind %0d addr %0d data %0d at cycle %0d, expected none",
                  kind, addr, data, cyc);
      end else begin
         e = expq.pop_front();
         check("op_cycle", cyc, e.cyc);
         check("op_kind", kind, e.kind);
         if (e.kind == 2) begin
            check("done_oob", o, e.oob);
         end else begin
            check("op_addr", addr, e.addr);
            if (e.kind == 1) check("op_wdata", data, e.data);
         end
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queue head
   always @(negedge clk) begin
      if (mon_en) begin
         check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
         check("re_we_exclusive", int'(mem_re & mem_we), 0);
         if (mem_re) observe(0, int'(mem_addr), 0, 0);
         if (mem_we) observe(1, int'(mem_addr), int'(mem_wdata), 0);
         if (done) observe(2, 0, 0, int'(oob));
         else check("oob_without_done", int'(oob), 0);
      end
   end

   // Issue one transaction; expectations come from the move/deposit rules.
   task automatic issue(input logic [7:0] p, input logic [1:0] s, input logic sv, input bit abort);
      int x, y, tx, ty, a, t, nv;
      bit off;
      @(posedge clk); #1;
      start = 1'b1; pos = p; step = s; solved = sv;
      t = cyc;
      x = int'(p[3:0]);
      y = int'(p[7:4]);
      tx = x; ty = y;
      case (s)
         2'd0: tx = x + 1;
         2'd1: tx = x - 1;
         2'd2: ty = y + 1;
         default: ty = y - 1;
      endcase
      off = (tx < 0) || (tx >= MAP_LEN) || (ty < 0) || (ty >= MAP_LEN);
      a = ty * MAP_LEN + tx;
      busy_lo = t + 1;
      if (off) begin
         push_exp(t + 2, 2, 0, 0, 1);
         busy_hi = t + 2;
      end else if (sv) begin
         ref_mem[a] = PH_MAX;
         push_exp(t + 1, 1, a, PH_MAX, 0);
         push_exp(t + 2, 2, 0, 0, 0);
         busy_hi = t + 2;
      end else begin
         push_exp(t + 1, 0, a, 0, 0);
         if (abort) begin
            busy_hi = t + 1;
         end else begin
            nv = ref_mem[a] + DEPOSIT;
            if (nv > PH_MAX) nv = PH_MAX;
            ref_mem[a] = nv;
            push_exp(t + 2, 1, a, nv, 0);
            push_exp(t + 3, 2, 0, 0, 0);
            busy_hi = t + 3;
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      pos = 8'($urandom);
      step = 2'($urandom);
      solved = 1'($urandom);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_timeout", int'(ok), 1);
   endtask

   task automatic set_cell(input int a, input int v);
      ram[a] = PH_W'(v);
      ref_mem[a] = v;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_oob"}, int'(oob), 0);
      check({tag, "_mem_re"}, int'(mem_re), 0);
      check({tag, "_mem_we"}, int'(mem_we), 0);
      check({tag, "_mem_addr"}, int'(mem_addr), 0);
      check({tag, "_mem_wdata"}, int'(mem_wdata), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] p;
      for (int i = 0; i < CELLS; i++) set_cell(i, int'($urandom_range(0, 255)));

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      mon_en = 1'b1;

      // Basic deposit: {3,5} +x -> cell 36, 10 -> 14
      set_cell(36, 10);
      issue(8'h35, 2'd0, 1'b0, 1'b0);
      wait_idle();
      check("deposit_ram36", int'(ram[36]), 14);

      // Saturation
      set_cell(23, 253);
      issue(8'h22, 2'd0, 1'b0, 1'b0);
      wait_idle();
      check("sat_253", int'(ram[23]), 255);
      set_cell(34, 255);
      issue(8'h44, 2'd3, 1'b0, 1'b0);
      wait_idle();
      check("sat_255", int'(ram[34]), 255);

      // Solved marking
      set_cell(10, 7);
      issue(8'h00, 2'd2, 1'b1, 1'b0);
      wait_idle();
      check("solved_ram10", int'(ram[10]), 255);

      // Off-map targets
      issue(8'h99, 2'd0, 1'b0, 1'b0);
      wait_idle();
      issue(8'h00, 2'd1, 1'b0, 1'b0);
      wait_idle();
      issue(8'h90, 2'd2, 1'b1, 1'b0);
      wait_idle();

      // Starts while busy are ignored; the next one right after FIN is taken
      issue(8'h12, 2'd1, 1'b0, 1'b0);
      start = 1'b1; pos = 8'h55; step = 2'd0; solved = 1'b1;
      @(posedge clk); #1;
      pos = 8'h66;
      @(posedge clk); #1;
      start = 1'b0;
      issue(8'h57, 2'd2, 1'b0, 1'b0);
      wait_idle();

      // Reset one cycle into a deposit: read seen, no write afterwards
      issue(8'h34, 2'd0, 1'b0, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("abort");
      // start coincident with reset is dropped
      start = 1'b1; pos = 8'h33; step = 2'd0; solved = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b0;
      check_all_zero("start_in_rst");
      check("abort_queue_empty", expq.size(), 0);

      // Randomized traffic
      repeat (200) begin
         if ($urandom_range(0, 3) == 0) begin
            p = 8'($urandom);
         end else begin
            p[3:0] = 4'($urandom_range(0, 10));
            p[7:4] = 4'($urandom_range(0, 10));
         end
         issue(p, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
         wait_idle();
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (5) @(posedge clk);
      #1;
      check("final_queue_empty", expq.size(), 0);
      for (int i = 0; i < CELLS; i++) begin
         if (int'(ram[i]) != ref_mem[i]) check("final_ram", int'(ram[i]), ref_mem[i]);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
